// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, commit and redirect signals of the reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RoB_WIDTH  = 4
);
  // dispatch allocation and operand lookup
  logic                  DPRoB_en;
  logic [1:0]            DPRoB_type;
  logic [4:0]            DPRoB_rd;
  logic [ADDR_WIDTH-1:0] DPRoB_pred_pc;
  logic                  RoBDP_full;
  logic [RoB_WIDTH-1:0]  RoBDP_tail;
  logic [RoB_WIDTH:0]    DPRoB_Qj;
  logic [RoB_WIDTH:0]    DPRoB_Qk;
  logic                  RoBDP_j_ready;
  logic                  RoBDP_k_ready;
  logic [31:0]           RoBDP_j_value;
  logic [31:0]           RoBDP_k_value;
  // common data bus
  logic                  CDBRoB_RS_en;
  logic [RoB_WIDTH-1:0]  CDBRoB_RS_RoB_index;
  logic [31:0]           CDBRoB_RS_value;
  logic [ADDR_WIDTH-1:0] CDBRoB_RS_next_pc;
  logic                  CDBRoB_LSB_en;
  logic [RoB_WIDTH-1:0]  CDBRoB_LSB_RoB_index;
  logic [31:0]           CDBRoB_LSB_value;
  // commit and redirect
  logic                  RoBRF_en;
  logic [4:0]            RoBRF_rd;
  logic [31:0]           RoBRF_value;
  logic [RoB_WIDTH-1:0]  RoBRF_RoB_index;
  logic                  RoBLSB_commit_en;
  logic [RoB_WIDTH-1:0]  RoBLSB_RoB_index;
  logic                  RoBRS_pre_judge;
  logic [ADDR_WIDTH-1:0] RoBIF_next_pc;

  modport master (
    output DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pred_pc, DPRoB_Qj, DPRoB_Qk,
           CDBRoB_RS_en, CDBRoB_RS_RoB_index, CDBRoB_RS_value, CDBRoB_RS_next_pc,
           CDBRoB_LSB_en, CDBRoB_LSB_RoB_index, CDBRoB_LSB_value,
    input  RoBDP_full, RoBDP_tail, RoBDP_j_ready, RoBDP_k_ready, RoBDP_j_value,
           RoBDP_k_value, RoBRF_en, RoBRF_rd, RoBRF_value, RoBRF_RoB_index,
           RoBLSB_commit_en, RoBLSB_RoB_index, RoBRS_pre_judge, RoBIF_next_pc
  );

  modport slave (
    input  DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pred_pc, DPRoB_Qj, DPRoB_Qk,
           CDBRoB_RS_en, CDBRoB_RS_RoB_index, CDBRoB_RS_value, CDBRoB_RS_next_pc,
           CDBRoB_LSB_en, CDBRoB_LSB_RoB_index, CDBRoB_LSB_value,
    output RoBDP_full, RoBDP_tail, RoBDP_j_ready, RoBDP_k_ready, RoBDP_j_value,
           RoBDP_k_value, RoBRF_en, RoBRF_rd, RoBRF_value, RoBRF_RoB_index,
           RoBLSB_commit_en, RoBLSB_RoB_index, RoBRS_pre_judge, RoBIF_next_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete from CDB, retire at head,
// flush the machine for one cycle when a branch/jump target was mispredicted.
module reorder_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RoB_WIDTH  = 4
) (
  input  logic           Sys_clk,
  input  logic           Sys_rst_n,
  input  logic           Sys_rdy,
  reorder_buffer_if.slave rob
);
  localparam int unsigned RoB_SIZE = 1 << RoB_WIDTH;
  localparam int unsigned NON_DEP  = 1 << RoB_WIDTH;
  localparam int unsigned CNT_W    = RoB_WIDTH + 1;

  typedef enum logic [1:0] {
    TY_REG    = 2'd0,
    TY_BRANCH = 2'd1,
    TY_JUMP   = 2'd2,
    TY_STORE  = 2'd3
  } rob_type_e;

  logic [RoB_SIZE-1:0]   busy_q, busy_d, ready_q, ready_d;
  rob_type_e             type_q    [RoB_SIZE];
  rob_type_e             type_d    [RoB_SIZE];
  logic [4:0]            rd_q      [RoB_SIZE];
  logic [4:0]            rd_d      [RoB_SIZE];
  logic [31:0]           value_q   [RoB_SIZE];
  logic [31:0]           value_d   [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] next_pc_q [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] next_pc_d [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] pred_pc_q [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] pred_pc_d [RoB_SIZE];
  logic [RoB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rf_en_q, rf_en_d, lsb_en_q, lsb_en_d, pre_judge_q, pre_judge_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [31:0]           rf_value_q, rf_value_d;
  logic [RoB_WIDTH-1:0]  rf_idx_q, rf_idx_d, lsb_idx_q, lsb_idx_d;
  logic [ADDR_WIDTH-1:0] if_next_pc_q, if_next_pc_d;
  logic                  full, alloc, commit, mispredict;
  logic [32:0]           j_res, k_res;

  assign full = (count_q == CNT_W'(RoB_SIZE));

  // Operand tag resolution with same-cycle CDB bypass.
  function automatic logic [32:0] lookup(
    input logic [RoB_WIDTH:0]   tag,
    input logic                 ent_rdy,
    input logic [31:0]          ent_val,
    input logic                 rs_en,
    input logic [RoB_WIDTH-1:0] rs_idx,
    input logic [31:0]          rs_val,
    input logic                 ls_en,
    input logic [RoB_WIDTH-1:0] ls_idx,
    input logic [31:0]          ls_val
  );
    if (tag == CNT_W'(NON_DEP))                     return {1'b1, 32'd0};
    else if (rs_en && rs_idx == tag[RoB_WIDTH-1:0]) return {1'b1, rs_val};
    else if (ls_en && ls_idx == tag[RoB_WIDTH-1:0]) return {1'b1, ls_val};
    else                                            return {ent_rdy, ent_val};
  endfunction

  // Combinational lookups for both source operands.
  always_comb begin
    j_res = lookup(rob.DPRoB_Qj, ready_q[rob.DPRoB_Qj[RoB_WIDTH-1:0]],
                   value_q[rob.DPRoB_Qj[RoB_WIDTH-1:0]],
                   rob.CDBRoB_RS_en, rob.CDBRoB_RS_RoB_index, rob.CDBRoB_RS_value,
                   rob.CDBRoB_LSB_en, rob.CDBRoB_LSB_RoB_index, rob.CDBRoB_LSB_value);
    k_res = lookup(rob.DPRoB_Qk, ready_q[rob.DPRoB_Qk[RoB_WIDTH-1:0]],
                   value_q[rob.DPRoB_Qk[RoB_WIDTH-1:0]],
                   rob.CDBRoB_RS_en, rob.CDBRoB_RS_RoB_index, rob.CDBRoB_RS_value,
                   rob.CDBRoB_LSB_en, rob.CDBRoB_LSB_RoB_index, rob.CDBRoB_LSB_value);
  end

  // Next state: writeback, allocation, commit and mispredict flush.
  always_comb begin
    busy_d = busy_q;   ready_d = ready_q;   type_d = type_q;     rd_d = rd_q;
    value_d = value_q; next_pc_d = next_pc_q; pred_pc_d = pred_pc_q;
    head_d = head_q;   tail_d = tail_q;     count_d = count_q;
    rf_rd_d = rf_rd_q; rf_value_d = rf_value_q; rf_idx_d = rf_idx_q;
    lsb_idx_d = lsb_idx_q; if_next_pc_d = if_next_pc_q;
    rf_en_d = 1'b0;    lsb_en_d = 1'b0;     pre_judge_d = 1'b1;
    alloc = 1'b0;      commit = 1'b0;       mispredict = 1'b0;

    if (!Sys_rdy) begin
      rf_en_d     = rf_en_q;
      lsb_en_d    = lsb_en_q;
      pre_judge_d = pre_judge_q;
    end else if (pre_judge_q) begin
      if (rob.CDBRoB_RS_en && busy_q[rob.CDBRoB_RS_RoB_index]) begin
        ready_d[rob.CDBRoB_RS_RoB_index]   = 1'b1;
        value_d[rob.CDBRoB_RS_RoB_index]   = rob.CDBRoB_RS_value;
        next_pc_d[rob.CDBRoB_RS_RoB_index] = rob.CDBRoB_RS_next_pc;
      end
      if (rob.CDBRoB_LSB_en && busy_q[rob.CDBRoB_LSB_RoB_index]) begin
        ready_d[rob.CDBRoB_LSB_RoB_index] = 1'b1;
        value_d[rob.CDBRoB_LSB_RoB_index] = rob.CDBRoB_LSB_value;
      end

      alloc = rob.DPRoB_en && !full;
      if (alloc) begin
        busy_d[tail_q]    = 1'b1;
        type_d[tail_q]    = rob_type_e'(rob.DPRoB_type);
        ready_d[tail_q]   = (rob_type_e'(rob.DPRoB_type) == TY_STORE);
        rd_d[tail_q]      = rob.DPRoB_rd;
        value_d[tail_q]   = '0;
        next_pc_d[tail_q] = '0;
        pred_pc_d[tail_q] = rob.DPRoB_pred_pc;
        tail_d            = tail_q + RoB_WIDTH'(1);
      end

      commit = busy_q[head_q] && ready_q[head_q];
      if (commit) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + RoB_WIDTH'(1);
        if (type_q[head_q] == TY_REG || type_q[head_q] == TY_JUMP) begin
          rf_en_d    = 1'b1;
          rf_rd_d    = rd_q[head_q];
          rf_value_d = value_q[head_q];
          rf_idx_d   = head_q;
        end
        if (type_q[head_q] == TY_STORE) begin
          lsb_en_d  = 1'b1;
          lsb_idx_d = head_q;
        end
        if ((type_q[head_q] == TY_BRANCH || type_q[head_q] == TY_JUMP) &&
            next_pc_q[head_q] != pred_pc_q[head_q])
          mispredict = 1'b1;
      end

      if (alloc && !commit)      count_d = count_q + CNT_W'(1);
      else if (!alloc && commit) count_d = count_q - CNT_W'(1);

      if (mispredict) begin
        busy_d       = '0;
        head_d       = '0;
        tail_d       = '0;
        count_d      = '0;
        pre_judge_d  = 1'b0;
        if_next_pc_d = next_pc_q[head_q];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      busy_q <= '0; ready_q <= '0;
      for (int unsigned i = 0; i < RoB_SIZE; i++) begin
        type_q[i] <= TY_REG; rd_q[i] <= '0; value_q[i] <= '0;
        next_pc_q[i] <= '0;  pred_pc_q[i] <= '0;
      end
      head_q <= '0; tail_q <= '0; count_q <= '0;
      rf_en_q <= 1'b0; rf_rd_q <= '0; rf_value_q <= '0; rf_idx_q <= '0;
      lsb_en_q <= 1'b0; lsb_idx_q <= '0; pre_judge_q <= 1'b1; if_next_pc_q <= '0;
    end else begin
      busy_q <= busy_d; ready_q <= ready_d; type_q <= type_d; rd_q <= rd_d;
      value_q <= value_d; next_pc_q <= next_pc_d; pred_pc_q <= pred_pc_d;
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
      rf_en_q <= rf_en_d; rf_rd_q <= rf_rd_d; rf_value_q <= rf_value_d; rf_idx_q <= rf_idx_d;
      lsb_en_q <= lsb_en_d; lsb_idx_q <= lsb_idx_d; pre_judge_q <= pre_judge_d;
      if_next_pc_q <= if_next_pc_d;
    end
  end

  assign rob.RoBDP_full       = full;
  assign rob.RoBDP_tail       = tail_q;
  assign rob.RoBDP_j_ready    = j_res[32];
  assign rob.RoBDP_j_value    = j_res[31:0];
  assign rob.RoBDP_k_ready    = k_res[32];
  assign rob.RoBDP_k_value    = k_res[31:0];
  assign rob.RoBRF_en         = rf_en_q;
  assign rob.RoBRF_rd         = rf_rd_q;
  assign rob.RoBRF_value      = rf_value_q;
  assign rob.RoBRF_RoB_index  = rf_idx_q;
  assign rob.RoBLSB_commit_en = lsb_en_q;
  assign rob.RoBLSB_RoB_index = lsb_idx_q;
  assign rob.RoBRS_pre_judge  = pre_judge_q;
  assign rob.RoBIF_next_pc    = if_next_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against a queue-based model.
module tb_reorder_buffer;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 4;

  logic Sys_clk = 1'b0;
  logic Sys_rst_n;
  logic Sys_rdy;

  reorder_buffer_if #(.ADDR_WIDTH(AW), .RoB_WIDTH(RW)) bus ();

  reorder_buffer #(.ADDR_WIDTH(AW), .RoB_WIDTH(RW)) dut (
    .Sys_clk  (Sys_clk),
    .Sys_rst_n(Sys_rst_n),
    .Sys_rdy  (Sys_rdy),
    .rob      (bus)
  );

  always #5 Sys_clk = ~Sys_clk;

  typedef struct {
    int unsigned idx;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pred;
    logic [31:0] val;
    logic [31:0] npc;
    bit          rdy;
  } ent_t;

  typedef struct {
    int unsigned edge_no;
    bit          rf_en;
    bit          lsb_en;
    bit          pj;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  idx;
    logic [31:0] npc;
  } exp_t;

  ent_t        mq[$];          // in-flight instructions, oldest first
  exp_t        sb[$];          // expected commit-side events
  int unsigned m_tail = 0;
  bit          m_flush = 0;
  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge Sys_clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    Sys_rdy = 1'b1;
    bus.DPRoB_en = 1'b0; bus.DPRoB_type = 2'd0; bus.DPRoB_rd = 5'd0; bus.DPRoB_pred_pc = '0;
    bus.DPRoB_Qj = 5'd16; bus.DPRoB_Qk = 5'd16;
    bus.CDBRoB_RS_en = 1'b0; bus.CDBRoB_RS_RoB_index = '0;
    bus.CDBRoB_RS_value = '0; bus.CDBRoB_RS_next_pc = '0;
    bus.CDBRoB_LSB_en = 1'b0; bus.CDBRoB_LSB_RoB_index = '0; bus.CDBRoB_LSB_value = '0;
  endtask

  task automatic lookup_exp(input logic [4:0] tag, output bit known, output bit r,
                            output logic [31:0] v);
    logic [3:0] t;
    t = tag[3:0];
    known = 0; r = 0; v = '0;
    if (tag == 5'd16) begin known = 1; r = 1; v = '0; end
    else if (bus.CDBRoB_RS_en && bus.CDBRoB_RS_RoB_index == t) begin
      known = 1; r = 1; v = bus.CDBRoB_RS_value;
    end else if (bus.CDBRoB_LSB_en && bus.CDBRoB_LSB_RoB_index == t) begin
      known = 1; r = 1; v = bus.CDBRoB_LSB_value;
    end else begin
      foreach (mq[i]) if (mq[i].idx == 32'(t)) begin known = 1; r = mq[i].rdy; v = mq[i].val; end
    end
  endtask

  // Advance the reference model across one active edge.
  task automatic model_step();
    bit   commit;
    ent_t c;
    ent_t e;
    exp_t x;
    if (m_flush) begin m_flush = 0; return; end
    commit = (mq.size() > 0) && mq[0].rdy;
    if (commit) c = mq[0];
    foreach (mq[i]) begin
      if (bus.CDBRoB_RS_en && mq[i].idx == 32'(bus.CDBRoB_RS_RoB_index)) begin
        mq[i].rdy = 1; mq[i].val = bus.CDBRoB_RS_value; mq[i].npc = bus.CDBRoB_RS_next_pc;
      end
      if (bus.CDBRoB_LSB_en && mq[i].idx == 32'(bus.CDBRoB_LSB_RoB_index)) begin
        mq[i].rdy = 1; mq[i].val = bus.CDBRoB_LSB_value;
      end
    end
    if (bus.DPRoB_en && mq.size() < 16) begin
      e.idx = m_tail; e.typ = bus.DPRoB_type; e.rd = bus.DPRoB_rd; e.pred = bus.DPRoB_pred_pc;
      e.val = '0; e.npc = '0; e.rdy = (bus.DPRoB_type == 2'd3);
      mq.push_back(e);
      m_tail = (m_tail + 1) % 16;
    end
    if (commit) begin
      e = mq.pop_front();
      x.edge_no = edge_cnt + 1;
      x.rf_en   = (c.typ == 2'd0) || (c.typ == 2'd2);
      x.lsb_en  = (c.typ == 2'd3);
      x.pj      = 1;
      x.rd      = c.rd; x.val = c.val; x.idx = 4'(c.idx); x.npc = c.npc;
      if ((c.typ == 2'd1 || c.typ == 2'd2) && c.npc != c.pred) begin
        x.pj = 0; mq.delete(); m_tail = 0; m_flush = 1;
      end
      if (x.rf_en || x.lsb_en || !x.pj) sb.push_back(x);
    end
  endtask

  // Check combinational outputs, update model, run one clock.
  task automatic cycle();
    bit known, r;
    logic [31:0] v;
    #1;
    chk("full", 32'(bus.RoBDP_full), 32'(mq.size() == 16));
    chk("tail", 32'(bus.RoBDP_tail), m_tail % 16);
    lookup_exp(bus.DPRoB_Qj, known, r, v);
    if (known) begin
      chk("j_ready", 32'(bus.RoBDP_j_ready), 32'(r));
      if (r) chk("j_value", bus.RoBDP_j_value, v);
    end
    lookup_exp(bus.DPRoB_Qk, known, r, v);
    if (known) begin
      chk("k_ready", 32'(bus.RoBDP_k_ready), 32'(r));
      if (r) chk("k_value", bus.RoBDP_k_value, v);
    end
    if (Sys_rdy) model_step();
    @(posedge Sys_clk);
    @(negedge Sys_clk);
  endtask

  // Random CDB traffic aimed at outstanding entries.
  task automatic rand_cdb();
    int cand[$];
    int rs_pick = -1;
    int k;
    foreach (mq[i]) if (!mq[i].rdy) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(1) == 1) begin
      k = cand[$urandom_range(cand.size() - 1)];
      rs_pick = k;
      bus.CDBRoB_RS_en = 1'b1;
      bus.CDBRoB_RS_RoB_index = 4'(mq[k].idx);
      bus.CDBRoB_RS_value = $urandom;
      bus.CDBRoB_RS_next_pc = ($urandom_range(7) == 0) ? mq[k].pred + 32'd4 : mq[k].pred;
      if ($urandom_range(1) == 1) bus.DPRoB_Qj = {1'b0, bus.CDBRoB_RS_RoB_index};
    end
    cand.delete();
    foreach (mq[i]) if (!mq[i].rdy && mq[i].typ == 2'd0 && i != rs_pick) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(1) == 1) begin
      k = cand[$urandom_range(cand.size() - 1)];
      bus.CDBRoB_LSB_en = 1'b1;
      bus.CDBRoB_LSB_RoB_index = 4'(mq[k].idx);
      bus.CDBRoB_LSB_value = $urandom;
      if ($urandom_range(1) == 1) bus.DPRoB_Qk = {1'b0, bus.CDBRoB_LSB_RoB_index};
    end
  endtask

  // Monitor: every commit-side event after an active edge is matched against the scoreboard.
  initial begin
    bit   act;
    exp_t x;
    forever begin
      @(posedge Sys_clk);
      act = Sys_rdy && Sys_rst_n;
      @(negedge Sys_clk);
      if (act && (bus.RoBRF_en || bus.RoBLSB_commit_en || !bus.RoBRS_pre_judge)) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_commit: rf_en=%0b lsb_en=%0b pre_judge=%0b with none expected",
                   bus.RoBRF_en, bus.RoBLSB_commit_en, bus.RoBRS_pre_judge);
        end else begin
          x = sb.pop_front();
          chk("commit_edge", edge_cnt, x.edge_no);
          chk("rf_en", 32'(bus.RoBRF_en), 32'(x.rf_en));
          chk("lsb_en", 32'(bus.RoBLSB_commit_en), 32'(x.lsb_en));
          chk("pre_judge", 32'(bus.RoBRS_pre_judge), 32'(x.pj));
          if (x.rf_en) begin
            chk("rf_rd", 32'(bus.RoBRF_rd), 32'(x.rd));
            chk("rf_value", bus.RoBRF_value, x.val);
            chk("rf_index", 32'(bus.RoBRF_RoB_index), 32'(x.idx));
          end
          if (x.lsb_en) chk("lsb_index", 32'(bus.RoBLSB_RoB_index), 32'(x.idx));
          if (!x.pj)    chk("redirect_pc", bus.RoBIF_next_pc, x.npc);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_en"}, 32'(bus.RoBRF_en), 32'd0);
    chk({tag, "_rf_rd"}, 32'(bus.RoBRF_rd), 32'd0);
    chk({tag, "_rf_value"}, bus.RoBRF_value, 32'd0);
    chk({tag, "_rf_index"}, 32'(bus.RoBRF_RoB_index), 32'd0);
    chk({tag, "_lsb_en"}, 32'(bus.RoBLSB_commit_en), 32'd0);
    chk({tag, "_lsb_index"}, 32'(bus.RoBLSB_RoB_index), 32'd0);
    chk({tag, "_pre_judge"}, 32'(bus.RoBRS_pre_judge), 32'd1);
    chk({tag, "_next_pc"}, bus.RoBIF_next_pc, 32'd0);
    chk({tag, "_tail"}, 32'(bus.RoBDP_tail), 32'd0);
    chk({tag, "_full"}, 32'(bus.RoBDP_full), 32'd0);
  endtask

  initial begin
    int guard;
    clear_inputs();
    Sys_rst_n = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge Sys_clk);
    Sys_rst_n = 1'b1;

    // REG rd=5 at index 0, completed by RS with 0x1234, retires next cycle.
    clear_inputs(); bus.DPRoB_en = 1'b1; bus.DPRoB_type = 2'd0; bus.DPRoB_rd = 5'd5;
    cycle();
    clear_inputs(); bus.CDBRoB_RS_en = 1'b1; bus.CDBRoB_RS_RoB_index = 4'd0;
    bus.CDBRoB_RS_value = 32'h1234;
    cycle();
    clear_inputs();
    cycle();

    // Fill all 16 entries, try a 17th, then retire one and allocate again.
    for (int i = 0; i < 17; i++) begin
      clear_inputs(); bus.DPRoB_en = 1'b1; bus.DPRoB_rd = 5'(i + 1);
      cycle();
    end
    clear_inputs(); bus.CDBRoB_RS_en = 1'b1;
    bus.CDBRoB_RS_RoB_index = 4'(mq[0].idx); bus.CDBRoB_RS_value = 32'hCAFE;
    cycle();
    clear_inputs(); bus.DPRoB_en = 1'b1;
    cycle();
    clear_inputs(); bus.DPRoB_en = 1'b1; bus.DPRoB_rd = 5'd31;
    cycle();

    // Randomized traffic including stalls, stores and mispredicts.
    for (int n = 0; n < 2500; n++) begin
      clear_inputs();
      Sys_rdy = ($urandom_range(9) != 0);
      bus.DPRoB_en = ($urandom_range(2) != 0);
      bus.DPRoB_type = 2'($urandom_range(3));
      bus.DPRoB_rd = 5'($urandom);
      bus.DPRoB_pred_pc = $urandom & 32'hFFFF_FFFC;
      bus.DPRoB_Qj = 5'($urandom_range(16));
      bus.DPRoB_Qk = 5'($urandom_range(16));
      rand_cdb();
      cycle();
    end

    // Drain everything outstanding.
    guard = 0;
    while ((mq.size() > 0 || m_flush) && guard < 400) begin
      clear_inputs();
      rand_cdb();
      cycle();
      guard++;
    end
    chk("drain_empty", 32'(mq.size()), 32'd0);

    // STORE commits one cycle after allocation.
    clear_inputs(); bus.DPRoB_en = 1'b1; bus.DPRoB_type = 2'd3;
    cycle();
    clear_inputs();
    cycle();
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset while the store commit pulse is on the outputs.
    Sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    repeat (2) @(negedge Sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
